// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered NUM_IN-operand bitwise reduction with a
// selectable opcode, a 2-entry skid output buffer and an op-coverage tracker.
// The reduction is built from one bit-lane instance per result bit. All
// lanes share the opcode and reduce one bit column across every operand.

// Single bit lane: reduces one bit column of all operands.
module logic_gate_lane #(
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN-1:0] bits,
  input  logic [2:0]        op,
  output logic              res
);

  // Inverting ops invert the full reduction, not a chain of 2-input gates.
  always_comb begin
    res = 1'b0;
    case (op)
      3'd0:    res = &bits;
      3'd1:    res = |bits;
      3'd2:    res = ^bits;
      3'd3:    res = ~(&bits);
      3'd4:    res = ~(|bits);
      3'd5:    res = ~(^bits);
      default: res = 1'b0;
    endcase
  end

endmodule

module logic_gate_unit #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [5:0]              cov_seen,
  output logic                    cov_done,
  input  logic                    cov_clear
);

  // One buffered result. The opcode travels with the data so coverage can
  // be credited when the result is accepted, not when it is captured.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
    logic [2:0]       op;
  } ent_t;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [NUM_IN-1:0][WIDTH-1:0] opnd;
  logic [WIDTH-1:0]             red;
  logic                         illegal;
  ent_t                         new_e;

  logic [1:0] state_q, state_d;
  ent_t       main_q, main_d;
  ent_t       skid_q, skid_d;
  logic       rdy_q;
  logic [5:0] cov_q;
  logic       fire, acc;

  assign opnd = in_data;

  // Transpose operands into bit columns, one lane per result bit.
  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    logic [NUM_IN-1:0] col;
    for (genvar k = 0; k < NUM_IN; k++) begin : g_col
      assign col[k] = opnd[k][b];
    end
    logic_gate_lane #(.NUM_IN(NUM_IN)) u_lane (
      .bits (col),
      .op   (in_op),
      .res  (red[b])
    );
  end

  assign illegal    = (in_op > 3'd5);
  assign new_e.data = illegal ? '0 : red;
  assign new_e.err  = illegal;
  assign new_e.op   = in_op;

  assign fire = in_valid && rdy_q;
  assign acc  = out_valid && out_ready;

  // Skid buffer next state: main always holds the oldest result, skid the
  // younger one only while both are occupied.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (fire) begin
          main_d  = new_e;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (fire && acc) begin
          main_d = new_e;
        end else if (fire) begin
          skid_d  = new_e;
          state_d = S_TWO;
        end else if (acc) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (acc) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Buffer registers; in_ready is registered from the next state so
  // out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != S_TWO);
    end
  end

  // Coverage: credit a legal op when its result leaves; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_q <= '0;
    end else if (cov_clear) begin
      cov_q <= '0;
    end else if (acc && !main_q.err) begin
      cov_q <= cov_q | (6'b000001 << main_q.op);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q.data;
  assign out_err   = main_q.err;
  assign cov_seen  = cov_q;
  assign cov_done  = &cov_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: two instances (2 and 3 operands) share the
// handshake/opcode inputs; a queue-based model predicts every output.
module tb_logic_gate_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cov_clear;
  logic [2:0]  in_op;
  logic [15:0] in_data2;
  logic [23:0] in_data3;

  logic       rdy2, vld2, err2, done2, rdy3, vld3, err3, done3;
  logic [7:0] dat2, dat3;
  logic [5:0] cov2, cov3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .NUM_IN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data2), .in_op(in_op), .out_valid(vld2), .out_ready(out_ready),
    .out_data(dat2), .out_err(err2), .cov_seen(cov2), .cov_done(done2),
    .cov_clear(cov_clear)
  );

  logic_gate_unit #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data3), .in_op(in_op), .out_valid(vld3), .out_ready(out_ready),
    .out_data(dat3), .out_err(err3), .cov_seen(cov3), .cov_done(done3),
    .cov_clear(cov_clear)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [2:0] op;
  } ent_t;

  ent_t       q2[$];
  ent_t       q3[$];
  logic [5:0] mcov2, mcov3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference reduction from the op table: {err, data}.
  function automatic logic [8:0] ref_red(input logic [23:0] d, input int n, input logic [2:0] op);
    logic [7:0] a, o, x, v;
    a = 8'hFF; o = 8'h00; x = 8'h00;
    for (int k = 0; k < n; k++) begin
      v = d[k*8 +: 8];
      a = a & v; o = o | v; x = x ^ v;
    end
    case (op)
      3'd0: return {1'b0, a};
      3'd1: return {1'b0, o};
      3'd2: return {1'b0, x};
      3'd3: return {1'b0, ~a};
      3'd4: return {1'b0, ~o};
      3'd5: return {1'b0, ~x};
      default: return 9'h100;
    endcase
  endfunction

  function automatic ent_t mk(input logic [23:0] d, input int n, input logic [2:0] op);
    ent_t e;
    logic [8:0] r;
    r = ref_red(d, n, op);
    e.data = r[7:0]; e.err = r[8]; e.op = op;
    return e;
  endfunction

  // Behavioural model: each unit is a 2-deep FIFO, ready while not full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2.delete(); q3.delete();
      mcov2 = '0; mcov3 = '0;
    end else begin
      logic acc2, acc3, fire2, fire3;
      ent_t e;
      acc2  = (q2.size() > 0) && out_ready;
      acc3  = (q3.size() > 0) && out_ready;
      fire2 = in_valid && (q2.size() < 2);
      fire3 = in_valid && (q3.size() < 2);
      if (cov_clear) mcov2 = '0;
      if (cov_clear) mcov3 = '0;
      if (acc2) begin
        e = q2.pop_front();
        if (!cov_clear && !e.err) mcov2[e.op] = 1'b1;
      end
      if (acc3) begin
        e = q3.pop_front();
        if (!cov_clear && !e.err) mcov3[e.op] = 1'b1;
      end
      if (fire2) q2.push_back(mk({8'h00, in_data2}, 2, in_op));
      if (fire3) q3.push_back(mk(in_data3, 3, in_op));
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("rdy2", rdy2, q2.size() < 2);
    chk("vld2", vld2, q2.size() != 0);
    if (q2.size() != 0) begin
      chk("data2", dat2, q2[0].data);
      chk("err2", err2, q2[0].err);
    end
    chk("cov2", cov2, mcov2);
    chk("done2", done2, &mcov2);
    chk("rdy3", rdy3, q3.size() < 2);
    chk("vld3", vld3, q3.size() != 0);
    if (q3.size() != 0) begin
      chk("data3", dat3, q3[0].data);
      chk("err3", err3, q3[0].err);
    end
    chk("cov3", cov3, mcov3);
    chk("done3", done3, &mcov3);
  end

  task automatic step(input logic v, input logic [2:0] op, input logic [15:0] d2,
                      input logic [23:0] d3, input logic ordy, input logic clr);
    in_valid = v; in_op = op; in_data2 = d2; in_data3 = d3;
    out_ready = ordy; cov_clear = clr;
    @(posedge clk); #1;
  endtask

  logic [7:0] exp6 [6];

  initial begin
    exp6 = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_data2 = '0; in_data3 = '0;
    out_ready = 1'b0; cov_clear = 1'b0;

    // Pin the model against hand-computed values.
    for (int i = 0; i < 6; i++)
      chk("pin_op", ref_red(24'h00F0CC, 2, 3'(i)), {1'b0, exp6[i]});
    chk("pin_xnor3", ref_red(24'h010FFF, 3, 3'd5), 9'h00E);
    chk("pin_ill", ref_red(24'h00F0CC, 2, 3'd7), 9'h100);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", rdy2, 1'b1);
    chk("rst_vld", vld2, 1'b0);
    chk("rst_cov", cov2, 6'h00);
    chk("rst_done", done2, 1'b0);
    chk("rst_dat", dat2, 8'h00);
    rst_n = 1'b1;

    // Each op, one cycle after fire.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'(i), 16'hF0CC, 24'h00F0CC, 1'b1, 1'b0);
      chk("op_vld", vld2, 1'b1);
      chk("op_data", dat2, exp6[i]);
    end
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b0);
    chk("cov_full", cov2, 6'h3F);
    chk("cov_done", done2, 1'b1);

    // Three-operand XNOR is a true parity inversion.
    step(1'b1, 3'd5, 16'hF0CC, 24'h010FFF, 1'b1, 1'b0);
    chk("xnor3", dat3, 8'h0E);
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b0);

    // Backpressure: third transaction stalls, then strict order.
    step(1'b1, 3'd0, 16'hF0CC, 24'h00F0CC, 1'b0, 1'b0);
    chk("bp_rdy1", rdy2, 1'b1);
    step(1'b1, 3'd1, 16'hF0CC, 24'h00F0CC, 1'b0, 1'b0);
    chk("bp_rdy2", rdy2, 1'b0);
    step(1'b1, 3'd2, 16'hF0CC, 24'h00F0CC, 1'b0, 1'b0);
    chk("bp_hold", dat2, 8'hC0);
    step(1'b1, 3'd2, 16'hF0CC, 24'h00F0CC, 1'b1, 1'b0);
    chk("bp_or", dat2, 8'hFC);
    step(1'b1, 3'd2, 16'hF0CC, 24'h00F0CC, 1'b1, 1'b0);
    chk("bp_xor", dat2, 8'h3C);
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b0);
    chk("bp_empty", vld2, 1'b0);

    // Illegal opcode leaves coverage untouched.
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b1);
    chk("clr", cov2, 6'h00);
    step(1'b1, 3'd7, 16'hF0CC, 24'h00F0CC, 1'b1, 1'b0);
    chk("ill_data", dat2, 8'h00);
    chk("ill_err", err2, 1'b1);
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b0);
    chk("ill_cov", cov2, 6'h00);

    // Clear beats a same-cycle AND accept; without clear it is recorded.
    step(1'b1, 3'd0, 16'hF0CC, 24'h00F0CC, 1'b1, 1'b0);
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b1);
    chk("clr_prio", cov2, 6'h00);
    step(1'b1, 3'd0, 16'hF0CC, 24'h00F0CC, 1'b1, 1'b0);
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b0);
    chk("and_cov", cov2, 6'h01);

    // Asynchronous reset with two results buffered.
    step(1'b1, 3'd1, 16'h1234, 24'h123456, 1'b0, 1'b0);
    step(1'b1, 3'd2, 16'h5678, 24'h789ABC, 1'b0, 1'b0);
    chk("full_vld", vld2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", vld2, 1'b0);
    chk("arst_rdy", rdy2, 1'b1);
    chk("arst_cov", cov2, 6'h00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 16'($urandom),
           24'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 16'h0, 24'h0, 1'b1, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
